// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV64I pipeline: stall/flush generation,
// wrong-path fetch drain tracking and stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_write,
  input  logic                  ex_redirect,
  input  logic                  imem_busy,
  input  logic                  dmem_busy,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_stall,
  output logic                  idex_flush,
  output logic                  exmem_stall,
  output logic                  memwb_flush,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RSVD    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t state;
  logic   loaduse;
  logic   stall_inc;
  logic   flush_inc;

  always_comb begin
    loaduse = ex_is_load && ex_reg_write && (ex_rd != '0) &&
              ((id_rs1_used && (id_rs1 == ex_rd)) ||
               (id_rs2_used && (id_rs2 == ex_rd)));
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!rst) begin
      if (dmem_busy) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        memwb_flush = 1'b1;
        stall_inc   = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        flush_inc   = 1'b1;
      end else if (loaduse) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_flush  = 1'b1;
        stall_inc   = 1'b1;
      end else if (imem_busy) begin
        pc_stall    = 1'b1;
        ifid_flush  = 1'b1;
      end
      // The stale wrong-path response is discarded even on the cycle it arrives.
      if (state == DRAIN) ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
      case (state)
        RUN: begin
          if (!dmem_busy && ex_redirect && imem_busy) state <= DRAIN;
        end
        DRAIN: begin
          if (!dmem_busy && !imem_busy) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; a second instance with 4-bit counters checks wrap.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_is_load, ex_reg_write;
  logic       ex_redirect, imem_busy, dmem_busy;

  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt, flush_cnt;

  logic        w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall, w_idex_flush;
  logic        w_exmem_stall, w_memwb_flush;
  logic [1:0]  w_state_o;
  logic [3:0]  w_stall_cnt, w_flush_cnt;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .ex_redirect(ex_redirect),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .idex_flush(idex_flush), .exmem_stall(exmem_stall), .memwb_flush(memwb_flush),
    .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_reg_write(ex_reg_write), .ex_redirect(ex_redirect),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .pc_stall(w_pc_stall),
    .ifid_stall(w_ifid_stall), .ifid_flush(w_ifid_flush), .idex_stall(w_idex_stall),
    .idex_flush(w_idex_flush), .exmem_stall(w_exmem_stall), .memwb_flush(w_memwb_flush),
    .state_o(w_state_o), .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
  );

  typedef struct packed {
    logic [6:0]  ctl;   // {pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, memwb_f}
    logic [1:0]  st;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t        q[$];
  int          checks;
  int          errors;
  logic [1:0]  m_state;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_loaduse();
    if (!(ex_is_load && ex_reg_write) || ex_rd == 5'd0) return 1'b0;
    return (id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    if (dmem_busy)            e.ctl = 7'b1101011;
    else if (ex_redirect)     e.ctl = 7'b0010100;
    else if (model_loaduse()) e.ctl = 7'b1100100;
    else if (imem_busy)       e.ctl = 7'b1010000;
    else                      e.ctl = 7'b0000000;
    if (m_state == 2'd1) e.ctl[4] = 1'b1;
    e.st   = m_state;
    e.scnt = m_stall;
    e.fcnt = m_flush;
    return e;
  endfunction

  task automatic model_edge();
    if (dmem_busy) begin
      m_stall = m_stall + 1;
    end else begin
      if (ex_redirect) m_flush = m_flush + 1;
      else if (model_loaduse()) m_stall = m_stall + 1;
      m_state = (imem_busy && (ex_redirect || m_state == 2'd1)) ? 2'd1 : 2'd0;
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Inputs are driven at posedge+1; the pushed expectation is consumed at the negedge.
  task automatic step();
    exp_t e;
    q.push_back(predict());
    @(negedge clk);
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("ctl", {25'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                    exmem_stall, memwb_flush}, {25'd0, e.ctl});
      check("state", {30'd0, state_o}, {30'd0, e.st});
      check("stall_cnt", stall_cnt, e.scnt);
      check("flush_cnt", flush_cnt, e.fcnt);
      check("flush_cnt_w", {28'd0, w_flush_cnt}, {28'd0, e.fcnt[3:0]});
      check("stall_cnt_w", {28'd0, w_stall_cnt}, {28'd0, e.scnt[3:0]});
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_is_load = 1'b0; ex_reg_write = 1'b0;
    ex_redirect = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
    id_rs1 = rd; id_rs1_used = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {25'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                          exmem_stall, memwb_flush}, 32'd0);
    check({tag, "_state"}, {30'd0, state_o}, 32'd0);
    check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
    check({tag, "_flush_cnt"}, flush_cnt, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    clear_in();
    rst = 1'b1;
    ex_redirect = 1'b1;
    dmem_busy = 1'b1;
    #12;
    check_reset_outputs("reset");
    clear_in();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use, then the same with rd = x0
    set_loaduse(5'd5); step();
    clear_in();        step();
    set_loaduse(5'd0); step();
    clear_in();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    step();
    id_rs2_used = 1'b0; step();
    clear_in();

    // Redirect with idle fetch
    ex_redirect = 1'b1; step();
    clear_in();         step();

    // Redirect during fetch, imem busy 3 more cycles, then the low cycle
    ex_redirect = 1'b1; imem_busy = 1'b1; step();
    ex_redirect = 1'b0;
    repeat (3) step();
    imem_busy = 1'b0; step();
    step();

    // Memory wait masking redirect and load-use, then redirect takes effect
    set_loaduse(5'd9); ex_redirect = 1'b1; dmem_busy = 1'b1;
    repeat (4) step();
    dmem_busy = 1'b0; step();
    clear_in(); step();

    // dmem_busy while draining holds DRAIN; redirect in DRAIN with imem low exits
    ex_redirect = 1'b1; imem_busy = 1'b1; step();
    ex_redirect = 1'b0; dmem_busy = 1'b1; imem_busy = 1'b0; step();
    dmem_busy = 1'b0; set_loaduse(5'd3); imem_busy = 1'b1; step();
    clear_in(); ex_redirect = 1'b1; step();
    clear_in(); step();

    // Async reset in the middle of a drain
    ex_redirect = 1'b1; imem_busy = 1'b1; step();
    ex_redirect = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    imem_busy = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step();

    // Random mix
    for (int unsigned i = 0; i < 300; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      ex_is_load = 1'($urandom); ex_reg_write = 1'($urandom);
      ex_redirect = ($urandom_range(0, 3) == 0);
      imem_busy   = ($urandom_range(0, 2) == 0);
      dmem_busy   = ($urandom_range(0, 4) == 0);
      step();
    end

    // Counter wrap on the 4-bit instance: 17 redirects from reset
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ex_redirect = 1'b1;
    repeat (17) step();
    clear_in();
    step();
    @(negedge clk);
    check("wrap_flush_cnt_w", {28'd0, w_flush_cnt}, 32'd1);
    check("wrap_flush_cnt", flush_cnt, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RV64I core.
- Generates the stall/flush pairs consumed by the IFID, IDEX, EXMEM and MEMWB pipeline registers, plus the PC hold.
- Resolves load-use hazards, EX-stage redirects (branch/jump), instruction-fetch waits and data-memory waits.
- Tracks wrong-path fetches in flight with a small FSM and keeps stall/flush event counters.

Parameters:
- REG_ADDR_W, 5, architectural register index width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_reg_write  in  1  EX instruction writes rd
- ex_redirect  in  1  EX resolved a taken branch/jump or mispredict; PC loads target this cycle
- imem_busy  in  1  fetch not complete; no valid instruction from IF this cycle
- dmem_busy  in  1  MEM-stage access not complete
- pc_stall  out  1  hold PC
- ifid_stall  out  1
- ifid_flush  out  1
- idex_stall  out  1
- idex_flush  out  1
- exmem_stall  out  1
- memwb_flush  out  1  insert bubble into WB
- state_o  out  2  FSM state, for debug
- stall_cnt  out  CNT_W  cycles with pc_stall caused by load-use or dmem_busy
- flush_cnt  out  CNT_W  accepted redirect events

Behaviour:
- Stall/flush outputs are combinational from inputs and current state. FSM and counters update on posedge clk.
- Reset (asynchronous, any time, including mid-drain):
  - state = RUN, counters = 0.
  - All stall/flush outputs = 0 while rst is high.
- FSM states:
  - RUN = 0
  - DRAIN = 1: a wrong-path fetch is in flight.
  - State 2 is unused. State 3 is illegal and recovers to RUN on the next edge.
- Load-use hazard, loaduse = 1 when all hold:
  - ex_is_load & ex_reg_write & ex_rd != 0
  - and (id_rs1_used & rs1 == ex_rd) or (id_rs2_used & rs2 == ex_rd)
- Priority, highest first; exactly one rule drives the outputs each cycle:
  1. dmem_busy:
     - pc_stall = ifid_stall = idex_stall = exmem_stall = 1, memwb_flush = 1.
     - ex_redirect and loaduse are ignored. EX is frozen, so the redirect re-presents itself afterwards.
     - flush_cnt does not count.
  2. ex_redirect:
     - ifid_flush = idex_flush = 1, pc_stall = 0 (PC takes the target).
     - flush_cnt += 1.
     - If imem_busy is also 1: next state = DRAIN.
  3. loaduse:
     - pc_stall = ifid_stall = 1, idex_flush = 1 (one bubble).
     - Lasts exactly one cycle per load, since the load advances to MEM.
  4. imem_busy:
     - pc_stall = 1, ifid_flush = 1 (bubble into ID); downstream stages advance.
  5. Otherwise all outputs = 0.
- stall_cnt += 1 in any cycle where rule 1 or rule 3 applies.
- DRAIN state:
  - ifid_flush is forced to 1 in every cycle in DRAIN, including the cycle imem_busy falls, so the stale response is discarded. This is ORed with the rule result.
  - If rule 3 applies in DRAIN, ifid_stall = 1 and ifid_flush = 1 are both asserted; flush wins in IFID.
  - Exit to RUN on the first edge where imem_busy == 0.
  - A new ex_redirect while in DRAIN with imem_busy = 1 stays in DRAIN. With imem_busy = 0 it goes to RUN; its own fetch has not yet issued.
  - dmem_busy in DRAIN: the state is held; drop tracking continues on imem_busy.
- Counters wrap at 2^CNT_W. Stall and flush increments in the same cycle are both applied.
- A redirect and a load-use hazard in the same cycle: the redirect wins; the dependent ID instruction is flushed anyway.

Test Plan:
- Load-use: ex_is_load = 1, ex_reg_write = 1, ex_rd = 5, id_rs1 = 5, id_rs1_used = 1, one cycle.
  - Expect pc_stall = ifid_stall = idex_flush = 1 for 1 cycle, stall_cnt 0 -> 1.
  - Repeat with ex_rd = 0: expect no stall.
- Redirect, idle fetch: ex_redirect = 1, imem_busy = 0.
  - Expect ifid_flush = idex_flush = 1, pc_stall = 0, flush_cnt = 1, state_o stays 0.
- Redirect during fetch: ex_redirect with imem_busy = 1, then imem_busy held 3 more cycles.
  - Expect state_o = 1.
  - Expect ifid_flush = 1 for all 4 cycles after the redirect, including the imem_busy-low cycle, then RUN.
- Memory wait: dmem_busy = 1 for 4 cycles with ex_redirect = 1 and a load-use match.
  - Expect only the freeze pattern: memwb_flush = 1, no flushes, stall_cnt += 4, flush_cnt unchanged.
  - Then the redirect takes effect on the first cycle dmem_busy = 0.
- Async reset mid-DRAIN: assert rst between edges while state_o = 1.
  - Expect immediate state_o = 0, counters = 0, all outputs 0.
  - After release with imem_busy = 0: no spurious ifid_flush.
- Counter wrap: CNT_W = 4, 17 redirects.
  - Expect flush_cnt = 1.
